// File: rtl/joybus_rx_if.sv
// Joybus receiver bundle: raw bus line and receive window in, decoded bytes and frame status out.
interface joybus_rx_if;
  logic       JB_RX;
  logic       rx_en;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic       rx_done;
  logic       rx_err;
  logic [5:0] rx_byte_cnt;

  modport slave  (input JB_RX, rx_en, output rx_data, rx_vld, rx_done, rx_err, rx_byte_cnt);
  modport master (output JB_RX, rx_en, input rx_data, rx_vld, rx_done, rx_err, rx_byte_cnt);
endinterface

// File: rtl/joybus_rx.sv
// Joybus receiver: decodes pulse-width bit cells on the open-drain line into bytes and
// reports per-frame status once the line stays idle or the response window times out.
module joybus_rx #(
  parameter int unsigned CYC_PER_US = 50,
  parameter int unsigned RESP_TO_US = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  joybus_rx_if.slave bus
);

  localparam int unsigned SAMPLE  = 2 * CYC_PER_US;
  localparam int unsigned LOW_MIN = CYC_PER_US / 2;
  localparam int unsigned LOW_MAX = 4 * CYC_PER_US;
  localparam int unsigned IDLE_TO = 5 * CYC_PER_US;
  localparam int unsigned RESP_TO = RESP_TO_US * CYC_PER_US;
  localparam int unsigned TMR_MAX = (RESP_TO > LOW_MAX)
                                    ? ((RESP_TO > IDLE_TO) ? RESP_TO : IDLE_TO)
                                    : ((LOW_MAX > IDLE_TO) ? LOW_MAX : IDLE_TO);
  localparam int unsigned TW      = $clog2(TMR_MAX + 1);
  localparam int unsigned CW      = $clog2(SAMPLE + 1);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WAIT_START = 3'd1;
  localparam logic [2:0] S_LOW        = 3'd2;
  localparam logic [2:0] S_HIGH       = 3'd3;
  localparam logic [2:0] S_DONE       = 3'd4;
  localparam logic [2:0] S_RECOVER    = 3'd5;

  logic [2:0]    state, state_nx;
  logic [1:0]    sync_q;
  logic          line, line_d, fall, rise, sample_now;
  logic [TW-1:0] tmr, tmr_nx;
  logic [CW-1:0] cell_tmr, cell_nx;
  logic          sampled, sampled_nx;
  logic [2:0]    bit_cnt, bit_cnt_nx;
  logic [5:0]    byte_cnt, byte_cnt_nx;
  logic [6:0]    shreg, shreg_nx;
  logic          err, err_nx;
  logic          need_low, need_low_nx;
  logic [7:0]    rx_data_q, rx_data_nx;
  logic          rx_vld_q, rx_vld_nx;
  logic          rx_done_q, rx_done_nx;
  logic          rx_err_q, rx_err_nx;
  logic [5:0]    rx_byte_cnt_q, rx_byte_cnt_nx;

  assign line = sync_q[1];
  assign fall = line_d & ~line;
  assign rise = ~line_d & line;
  // cell_tmr runs from each falling edge across both phases so the mid-cell sample lands in either
  assign sample_now = ((state == S_LOW) || (state == S_HIGH)) && !sampled &&
                      (cell_tmr == CW'(SAMPLE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      sync_q        <= 2'b11;
      line_d        <= 1'b1;
      tmr           <= '0;
      cell_tmr      <= '0;
      sampled       <= 1'b0;
      bit_cnt       <= '0;
      byte_cnt      <= '0;
      shreg         <= '0;
      err           <= 1'b0;
      need_low      <= 1'b1;
      rx_data_q     <= '0;
      rx_vld_q      <= 1'b0;
      rx_done_q     <= 1'b0;
      rx_err_q      <= 1'b0;
      rx_byte_cnt_q <= '0;
    end else begin
      state         <= state_nx;
      sync_q        <= {sync_q[0], bus.JB_RX};
      line_d        <= line;
      tmr           <= tmr_nx;
      cell_tmr      <= cell_nx;
      sampled       <= sampled_nx;
      bit_cnt       <= bit_cnt_nx;
      byte_cnt      <= byte_cnt_nx;
      shreg         <= shreg_nx;
      err           <= err_nx;
      need_low      <= need_low_nx;
      rx_data_q     <= rx_data_nx;
      rx_vld_q      <= rx_vld_nx;
      rx_done_q     <= rx_done_nx;
      rx_err_q      <= rx_err_nx;
      rx_byte_cnt_q <= rx_byte_cnt_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    tmr_nx         = tmr;
    cell_nx        = cell_tmr;
    sampled_nx     = sampled;
    bit_cnt_nx     = bit_cnt;
    byte_cnt_nx    = byte_cnt;
    shreg_nx       = shreg;
    err_nx         = err;
    need_low_nx    = need_low;
    rx_data_nx     = rx_data_q;
    rx_vld_nx      = 1'b0;
    rx_done_nx     = 1'b0;
    rx_err_nx      = rx_err_q;
    rx_byte_cnt_nx = rx_byte_cnt_q;

    if (((state == S_LOW) || (state == S_HIGH)) && (cell_tmr != CW'(SAMPLE)))
      cell_nx = cell_tmr + CW'(1);

    // One sampled bit per cell; bytes assemble MSB first
    if (sample_now) begin
      sampled_nx = 1'b1;
      shreg_nx   = {shreg[5:0], line};
      if (bit_cnt == 3'd7) begin
        bit_cnt_nx  = '0;
        byte_cnt_nx = (byte_cnt == 6'd63) ? byte_cnt : byte_cnt + 6'd1;
        rx_data_nx  = {shreg, line};
        rx_vld_nx   = 1'b1;
      end else begin
        bit_cnt_nx = bit_cnt + 3'd1;
      end
    end

    case (state)
      S_IDLE: begin
        if (need_low) begin
          if (!bus.rx_en) need_low_nx = 1'b0;
        end else if (bus.rx_en) begin
          state_nx    = S_WAIT_START;
          tmr_nx      = '0;
          cell_nx     = '0;
          sampled_nx  = 1'b0;
          bit_cnt_nx  = '0;
          byte_cnt_nx = '0;
          shreg_nx    = '0;
          err_nx      = 1'b0;
        end
      end
      S_WAIT_START: begin
        if (fall) begin
          state_nx   = S_LOW;
          tmr_nx     = '0;
          cell_nx    = '0;
          sampled_nx = 1'b0;
        end else if (tmr == TW'(RESP_TO - 1)) begin
          state_nx    = S_DONE;
          err_nx      = 1'b1;
          byte_cnt_nx = '0;
        end else begin
          tmr_nx = tmr + TW'(1);
        end
      end
      S_LOW: begin
        if (rise) begin
          state_nx = (tmr < TW'(LOW_MIN)) ? S_RECOVER : S_HIGH;
          if (tmr < TW'(LOW_MIN)) err_nx = 1'b1;
          tmr_nx = '0;
        end else if (tmr == TW'(LOW_MAX - 1)) begin
          state_nx = S_RECOVER;
          err_nx   = 1'b1;
          tmr_nx   = '0;
        end else begin
          tmr_nx = tmr + TW'(1);
        end
      end
      S_HIGH: begin
        if (fall) begin
          // A new cell starting before the previous one was sampled is a malformed bit
          if (!sampled && !sample_now) err_nx = 1'b1;
          state_nx   = S_LOW;
          tmr_nx     = '0;
          cell_nx    = '0;
          sampled_nx = 1'b0;
        end else if (tmr == TW'(IDLE_TO - 1)) begin
          state_nx = S_DONE;
          if (bit_cnt != 3'd1) err_nx = 1'b1;
        end else begin
          tmr_nx = tmr + TW'(1);
        end
      end
      S_DONE: begin
        rx_done_nx     = 1'b1;
        rx_err_nx      = err;
        rx_byte_cnt_nx = byte_cnt;
        need_low_nx    = 1'b1;
        state_nx       = S_IDLE;
      end
      S_RECOVER: begin
        if (!line) begin
          tmr_nx = '0;
        end else if (tmr == TW'(IDLE_TO - 1)) begin
          state_nx = S_DONE;
          err_nx   = 1'b1;
        end else begin
          tmr_nx = tmr + TW'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase

    // Closing the receive window abandons the frame silently
    if (!bus.rx_en && (state != S_IDLE) && (state != S_DONE)) begin
      state_nx   = S_IDLE;
      rx_vld_nx  = 1'b0;
      rx_data_nx = rx_data_q;
    end
  end

  assign bus.rx_data     = rx_data_q;
  assign bus.rx_vld      = rx_vld_q;
  assign bus.rx_done     = rx_done_q;
  assign bus.rx_err      = rx_err_q;
  assign bus.rx_byte_cnt = rx_byte_cnt_q;

endmodule

// File: tb/tb_joybus_rx.sv
// Bench for joybus_rx: random-timed bit cells and random frames checked against a
// bit-list model of frame decoding, plus directed timeout/glitch/reset/abort scenarios.
module tb_joybus_rx;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  joybus_rx_if bus ();

  joybus_rx #(.CYC_PER_US(50), .RESP_TO_US(200)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned done_cnt = 0;
  int unsigned last_done_cyc = 0;
  int unsigned last_rise_cyc = 0;
  logic        last_err;
  logic [5:0]  last_cnt;
  logic [7:0]  got_q[$];
  bit          bits_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Collect every byte and frame report the DUT emits
  always @(negedge clk) begin
    if (bus.rx_vld === 1'b1) got_q.push_back(bus.rx_data);
    if (bus.rx_done === 1'b1) begin
      done_cnt++;
      last_err      = bus.rx_err;
      last_cnt      = bus.rx_byte_cnt;
      last_done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // A '1' is a short low then long high; a '0' the reverse; both jittered
  task automatic send_bit(input bit b);
    int unsigned lo, hi;
    if (b) begin
      lo = $urandom_range(60, 45);
      hi = $urandom_range(160, 140);
    end else begin
      lo = $urandom_range(160, 140);
      hi = $urandom_range(60, 40);
    end
    bus.JB_RX = 1'b0;
    cycles(lo);
    bus.JB_RX = 1'b1;
    last_rise_cyc = cyc;
    cycles(hi);
  endtask

  task automatic push_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) bits_q.push_back(v[i]);
  endtask

  task automatic send_all();
    foreach (bits_q[i]) send_bit(bits_q[i]);
  endtask

  task automatic arm();
    bus.rx_en = 1'b0;
    cycles(3);
    bus.rx_en = 1'b1;
    cycles(3);
    got_q.delete();
  endtask

  task automatic wait_done(input int unsigned d0, input int unsigned bound);
    for (int i = 0; i < int'(bound); i++) begin
      if (done_cnt != d0) break;
      @(negedge clk);
    end
  endtask

  // Reference: bits group into MSB-first bytes; a lone trailing bit is the stop bit
  task automatic run_frame(input string tag);
    int unsigned d0, n, full, rem, ecnt;
    logic [7:0]  exp_q[$];
    logic [7:0]  v;
    n    = bits_q.size();
    full = n / 8;
    rem  = n % 8;
    ecnt = (full > 63) ? 63 : full;
    for (int k = 0; k < int'(full); k++) begin
      v = '0;
      for (int j = 0; j < 8; j++) v = {v[6:0], bits_q[8*k + j]};
      exp_q.push_back(v);
    end
    arm();
    d0 = done_cnt;
    send_all();
    wait_done(d0, 1000);
    chk($sformatf("%s done", tag), 32'(done_cnt - d0), 32'd1);
    chk($sformatf("%s err", tag), 32'(last_err), 32'(rem != 1));
    chk($sformatf("%s cnt", tag), 32'(last_cnt), 32'(ecnt));
    chk($sformatf("%s nbytes", tag), 32'(got_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i])
      if (i < got_q.size())
        chk($sformatf("%s byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    bus.rx_en = 1'b0;
    cycles(3);
  endtask

  initial begin
    int unsigned d0, t0, nb, rem;
    rst_n     = 1'b0;
    bus.JB_RX = 1'b1;
    bus.rx_en = 1'b0;
    cycles(5);
    chk("rst rx_data", 32'(bus.rx_data), 32'd0);
    chk("rst rx_vld", 32'(bus.rx_vld), 32'd0);
    chk("rst rx_done", 32'(bus.rx_done), 32'd0);
    chk("rst rx_err", 32'(bus.rx_err), 32'd0);
    chk("rst rx_byte_cnt", 32'(bus.rx_byte_cnt), 32'd0);
    rst_n = 1'b1;
    cycles(5);

    // Single byte 0x05 with stop; report lands one idle timeout after the stop rises
    bits_q.delete();
    push_byte(8'h05);
    bits_q.push_back(1'b1);
    run_frame("b05");
    chk("b05 done_delay_ok", 32'((last_done_cyc - last_rise_cyc) >= 245 &&
                                (last_done_cyc - last_rise_cyc) <= 265), 32'd1);

    bits_q.delete();
    push_byte(8'h00);
    push_byte(8'h80);
    push_byte(8'hFF);
    bits_q.push_back(1'b1);
    run_frame("b3");

    for (int f = 0; f < 3; f++) begin
      bits_q.delete();
      nb  = $urandom_range(3, 1);
      rem = $urandom_range(3, 0);
      for (int i = 0; i < int'(nb); i++) push_byte(8'($urandom));
      for (int i = 0; i < int'(rem); i++) bits_q.push_back(1'($urandom));
      run_frame($sformatf("rnd%0d", f));
    end

    // No response at all: response timeout
    bus.rx_en = 1'b0;
    cycles(3);
    got_q.delete();
    d0 = done_cnt;
    bus.rx_en = 1'b1;
    t0 = cyc;
    wait_done(d0, 10100);
    chk("to done", 32'(done_cnt - d0), 32'd1);
    chk("to delay_ok", 32'((last_done_cyc - t0) >= 10000 && (last_done_cyc - t0) <= 10006), 32'd1);
    chk("to err", 32'(last_err), 32'd1);
    chk("to cnt", 32'(last_cnt), 32'd0);
    chk("to nbytes", 32'(got_q.size()), 32'd0);

    // Three good bits then a 5-cycle glitch
    arm();
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) send_bit(1'($urandom));
    bus.JB_RX = 1'b0;
    cycles(5);
    bus.JB_RX = 1'b1;
    wait_done(d0, 1000);
    chk("gl done", 32'(done_cnt - d0), 32'd1);
    chk("gl err", 32'(last_err), 32'd1);
    chk("gl cnt", 32'(last_cnt), 32'd0);
    chk("gl nbytes", 32'(got_q.size()), 32'd0);

    // 0xA5 then five loose bits and no stop
    bits_q.delete();
    push_byte(8'hA5);
    for (int i = 0; i < 5; i++) bits_q.push_back(1'($urandom));
    run_frame("a5p5");

    // Line stuck low past the longest legal low phase
    arm();
    d0 = done_cnt;
    bus.JB_RX = 1'b0;
    cycles(300);
    bus.JB_RX = 1'b1;
    wait_done(d0, 1000);
    chk("stuck done", 32'(done_cnt - d0), 32'd1);
    chk("stuck err", 32'(last_err), 32'd1);
    chk("stuck cnt", 32'(last_cnt), 32'd0);
    chk("stuck nbytes", 32'(got_q.size()), 32'd0);

    // Reset in the middle of a byte
    arm();
    bits_q.delete();
    push_byte(8'h3C);
    for (int i = 0; i < 4; i++) send_bit(bits_q[i]);
    bus.JB_RX = 1'b0;
    cycles(30);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst rx_data", 32'(bus.rx_data), 32'd0);
    chk("mrst rx_vld", 32'(bus.rx_vld), 32'd0);
    chk("mrst rx_done", 32'(bus.rx_done), 32'd0);
    chk("mrst rx_err", 32'(bus.rx_err), 32'd0);
    chk("mrst rx_byte_cnt", 32'(bus.rx_byte_cnt), 32'd0);
    bus.JB_RX = 1'b1;
    cycles(5);
    rst_n = 1'b1;
    cycles(3);
    // rx_en stayed high across reset: receiver must stay quiet
    got_q.delete();
    d0 = done_cnt;
    bits_q.push_back(1'b1);
    send_all();
    cycles(400);
    chk("post_rst quiet done", 32'(done_cnt - d0), 32'd0);
    chk("post_rst quiet nbytes", 32'(got_q.size()), 32'd0);
    run_frame("b3c");

    // Window closed mid-frame
    arm();
    d0 = done_cnt;
    bits_q.delete();
    push_byte(8'($urandom));
    bits_q.push_back(1'b1);
    for (int i = 0; i < 2; i++) send_bit(bits_q[i]);
    bus.rx_en = 1'b0;
    for (int i = 2; i < bits_q.size(); i++) send_bit(bits_q[i]);
    cycles(400);
    chk("abort done", 32'(done_cnt - d0), 32'd0);
    chk("abort nbytes", 32'(got_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/joybus_rx.md
JOYBUS_RX -- requirements
Module: joybus_rx

Interface
REQ-001 Parameters: CYC_PER_US, 50, clk cycles per microsecond; RESP_TO_US, 200, max wait from rx_en rise to first falling edge.
REQ-002 clk  input  1  system clock.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 JB_RX  input  1  open-drain bus line, asynchronous to clk, idles high.
REQ-005 rx_en  input  1  level; high = receive window open (console TX finished).
REQ-006 rx_data  output  8  last completed byte, MSB first on wire.
REQ-007 rx_vld  output  1  one-cycle pulse; rx_data holds a new byte.
REQ-008 rx_done  output  1  one-cycle pulse; frame ended.
REQ-009 rx_err  output  1  frame status, valid when rx_done pulses, held until next rx_done.
REQ-010 rx_byte_cnt  output  6  complete bytes in current frame, valid at rx_done, saturates at 63.

Function
REQ-011 JB_RX SHALL pass through a 2-flop synchronizer reset to 1; all edge detection SHALL use the synchronized signal.
REQ-012 Derived constants SHALL be SAMPLE=2*CYC_PER_US, LOW_MIN=CYC_PER_US/2, LOW_MAX=4*CYC_PER_US, IDLE_TO=5*CYC_PER_US, RESP_TO=RESP_TO_US*CYC_PER_US.
REQ-013 States SHALL be IDLE, WAIT_START, LOW, HIGH, DONE, RECOVER.
REQ-014 IDLE: rx_en=1 -> WAIT_START, clear bit/byte counters and timer.
REQ-015 WAIT_START: falling edge -> LOW, timer cleared; RESP_TO cycles without edge -> DONE with rx_err=1, rx_byte_cnt=0.
REQ-016 LOW: timer counts from falling edge; at timer==SAMPLE-1 the synchronized line value SHALL be shifted into the byte register LSB-side (high=1, low=0).
REQ-017 LOW: rising edge with timer<LOW_MIN -> error; timer reaching LOW_MAX with line low -> error -> RECOVER.
REQ-018 LOW: rising edge at/after LOW_MIN -> HIGH, timer cleared; a bit is counted only if the sample point was reached, else error.
REQ-019 On the 8th counted bit of a byte, rx_data SHALL update and rx_vld SHALL pulse the next cycle; byte counter increments (saturating), bit counter wraps to 0.
REQ-020 HIGH: falling edge -> LOW; IDLE_TO cycles of high -> DONE.
REQ-021 End of frame: partial bit count exactly 1 is the stop bit, discarded, rx_err=0; partial count 0 or 2..7 SHALL set rx_err=1; partial bits never reach rx_data.
REQ-022 DONE: rx_done pulses one cycle with rx_err and rx_byte_cnt, then -> IDLE; if rx_en still high, IDLE SHALL wait for rx_en low before rearming.
REQ-023 RECOVER: wait for line high for IDLE_TO cycles, then DONE with rx_err=1.
REQ-024 rx_en falling in any state except DONE SHALL abort to IDLE with no rx_done and no rx_vld.
REQ-025 Errors SHALL be sticky within a frame; later bytes still pulse rx_vld.
REQ-026 Timer width SHALL cover max(RESP_TO, LOW_MAX, IDLE_TO) without wrap.

Reset
REQ-027 On rst_n low: state IDLE, rx_data=0, rx_vld=0, rx_done=0, rx_err=0, rx_byte_cnt=0, synchronizer=1, counters=0, effective immediately.
REQ-028 Reset mid-frame SHALL discard partial byte; after release, no output until rx_en rises from low.

Verification
REQ-029 CYC_PER_US=50; rx_en=1; send 0x05 (bits 1us/3us low, 4us cells) + 1us stop -> one rx_vld with 0x05, rx_done ~250 cycles after stop rise, rx_err=0, cnt=1.
REQ-030 Send 0x00,0x80,0xFF + stop -> three rx_vld pulses in order, rx_done err=0 cnt=3.
REQ-031 rx_en=1, line idle -> rx_done exactly 10000 cycles (+sync latency) later, err=1, cnt=0, no rx_vld.
REQ-032 5-cycle low glitch after 3 good bits -> no rx_vld, rx_done err=1 cnt=0.
REQ-033 0xA5 then 5 bits, no stop -> rx_vld 0xA5, rx_done err=1 cnt=1; line held low 300 cycles -> RECOVER, err=1.
REQ-034 rst_n low mid-byte, rx_en toggled -> all outputs 0; next clean 0x3C frame received correctly; rx_en dropped mid-frame -> no rx_done.
